bcd_display_scan: RTL and testbench

//  Display-side consumer of the clock's BCD time bus.
//  - Takes the six BCD digits (sec/min/hour, right/left) and the ampm flag produced by the time counters.
//  - Time-multiplexes them onto one shared 7-segment bus with six digit enables.
//  - Snapshots all digits once per scan frame, so a rollover mid-frame never shows a torn time.
//  - Sits directly after the counter chain at the top level and drives the board display pins.

---
 rtl/clock_disp_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/bcd_display_scan.sv | 120 ++++++++++++
 tb/tb_bcd_display_scan.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the clock display path.
//  - SEG_* : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//  - NUM_DIGITS : number of multiplexed display digits
//  - digit_idx_t : scan position type (3 bits, values 0..5 used)
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned IDX_W      = 3;

    typedef logic [IDX_W-1:0] digit_idx_t;

    localparam digit_idx_t IDX_FIRST = 3'd0;
    localparam digit_idx_t IDX_LAST  = 3'd5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
// Ports:
//  i_bcd  in   4  BCD digit; codes 10..15 render as a dash
//  o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Scans the six BCD time digits onto one shared active-low 7-segment bus.
// All digits plus ampm are snapshotted once per frame (on the edge the scan
// wraps 5 -> 0) so a counter rollover never shows a torn time.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks the hour-tens digit
// when it is zero (its enable and the PM dot still drive).
// Ports:
//  clk            in   1  system clock, rising edge
//  clear          in   1  synchronous active-low reset
//  rsbcd..lhbcd   in   4  sec/min/hour ones/tens BCD digits
//  ampm           in   1  1 = PM, lights dp on the hour-tens digit
//  seg            out  7  segments {g,f,e,d,c,b,a}, active-low
//  an             out  6  digit enables, active-low, an[i] = digit i
//  dp             out  1  decimal point, active-low
module bcd_display_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] rsbcd,
    input  logic [3:0] lsbcd,
    input  logic [3:0] rmbcd,
    input  logic [3:0] lmbcd,
    input  logic [3:0] rhbcd,
    input  logic [3:0] lhbcd,
    input  logic       ampm,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);

    localparam int unsigned        PRESC_W   = $clog2(SCAN_DIV) + 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

    logic [PRESC_W-1:0]              r_presc;
    digit_idx_t                      r_idx;
    logic [NUM_DIGITS-1:0][3:0]      r_snap;
    logic                            r_snap_ampm;
    logic [5:0]                      r_an;
    logic [6:0]                      r_seg;
    logic                            r_dp;

    logic       w_tick;
    logic       w_frame_end;
    logic [3:0] w_digit;
    logic [6:0] w_seg_dec;
    logic [6:0] w_seg_next;
    logic [5:0] w_an_next;
    logic       w_dp_next;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_frame_end = w_tick && (r_idx == IDX_LAST);

    // Prescaler, scan index and per-frame snapshot.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_presc     <= '0;
            r_idx       <= IDX_FIRST;
            r_snap      <= '0;
            r_snap_ampm <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? IDX_FIRST : r_idx + 3'd1;
            end
            if (w_frame_end) begin
                r_snap      <= {lhbcd, rhbcd, lmbcd, rmbcd, lsbcd, rsbcd};
                r_snap_ampm <= ampm;
            end
        end
    end

    // Snapshot mux; index values 6/7 never occur.
    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_an_next = ~(6'b000001 << r_idx);
        w_dp_next = ~((r_idx == IDX_LAST) && r_snap_ampm);
`ifdef LEADING_ZERO_BLANK_EN
        w_seg_next = ((r_idx == IDX_LAST) && (w_digit == 4'd0)) ? SEG_BLANK : w_seg_dec;
`else
        w_seg_next = w_seg_dec;
`endif
    end

    // Registered outputs: one cycle behind idx/snapshot, dark during reset.
    always_ff @(posedge clk) begin
        if (!clear) begin
            r_an  <= 6'b111111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized bench for bcd_display_scan. Two instances (SCAN_DIV=4 and
// SCAN_DIV=1) share the digit inputs but have independent clears. The
// reference model derives the displayed digit from the cycle count since
// reset and a frame-level snapshot of the inputs.
module tb_bcd_display_scan;

    logic       clk;
    logic       clear4, clear1;
    logic [3:0] rsbcd, lsbcd, rmbcd, lmbcd, rhbcd, lhbcd;
    logic       ampm;
    logic [6:0] seg4, seg1;
    logic [5:0] an4, an1;
    logic       dp4, dp1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset release and current frame snapshot.
    int          k4, k1;
    logic [24:0] snap4, snap1;

    localparam logic [13:0] DARK = {6'b111111, 7'b1111111, 1'b1};

    bcd_display_scan #(.SCAN_DIV(4)) u_dut4 (
        .clk   (clk),
        .clear (clear4),
        .rsbcd (rsbcd),
        .lsbcd (lsbcd),
        .rmbcd (rmbcd),
        .lmbcd (lmbcd),
        .rhbcd (rhbcd),
        .lhbcd (lhbcd),
        .ampm  (ampm),
        .seg   (seg4),
        .an    (an4),
        .dp    (dp4)
    );

    bcd_display_scan #(.SCAN_DIV(1)) u_dut1 (
        .clk   (clk),
        .clear (clear1),
        .rsbcd (rsbcd),
        .lsbcd (lsbcd),
        .rmbcd (rmbcd),
        .lmbcd (lmbcd),
        .rhbcd (rhbcd),
        .lhbcd (lhbcd),
        .ampm  (ampm),
        .seg   (seg1),
        .an    (an1),
        .dp    (dp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Output registered at edge k (k = 0 is the first edge after release).
    function automatic logic [13:0] model_out(input int d, input int k, input logic [24:0] snap);
        int         pos;
        logic [5:0] an_e;
        logic [6:0] seg_e;
        logic [3:0] dig;
        logic       dp_e;
        pos       = (k / d) % 6;
        an_e      = 6'b111111;
        an_e[pos] = 1'b0;
        dig       = snap[pos*4 +: 4];
        seg_e     = ref_dec(dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 5 && dig == 4'd0) seg_e = 7'b1111111;
`endif
        dp_e = !(pos == 5 && snap[24]);
        return {an_e, seg_e, dp_e};
    endfunction

    task automatic step();
        logic [24:0] cur;
        logic [13:0] e4, e1;
        @(posedge clk);
        cur = {ampm, lhbcd, rhbcd, lmbcd, rmbcd, lsbcd, rsbcd};
        if (!clear4) begin
            e4 = DARK; k4 = 0; snap4 = '0;
        end else begin
            e4 = model_out(4, k4, snap4);
            if ((k4 + 1) % 24 == 0) snap4 = cur;
            k4++;
        end
        if (!clear1) begin
            e1 = DARK; k1 = 0; snap1 = '0;
        end else begin
            e1 = model_out(1, k1, snap1);
            if ((k1 + 1) % 6 == 0) snap1 = cur;
            k1++;
        end
        #1;
        check("an_div4",  32'(an4),  32'(e4[13:8]));
        check("seg_div4", 32'(seg4), 32'(e4[7:1]));
        check("dp_div4",  32'(dp4),  32'(e4[0]));
        check("an_div1",  32'(an1),  32'(e1[13:8]));
        check("seg_div1", 32'(seg1), 32'(e1[7:1]));
        check("dp_div1",  32'(dp1),  32'(e1[0]));
    endtask

    initial begin
        k4 = 0; k1 = 0; snap4 = '0; snap1 = '0;
        clear4 = 1'b0; clear1 = 1'b0;
        {rsbcd, lsbcd, rmbcd, lmbcd, rhbcd, lhbcd} = '0;
        ampm = 1'b0;

        // Reset held three cycles, then release.
        repeat (3) step();
        clear4 = 1'b1; clear1 = 1'b1;

        // Fixed digits across two full slow frames, PM set.
        rsbcd = 4'd1; lsbcd = 4'd2; rmbcd = 4'd3; lmbcd = 4'd4; rhbcd = 4'd5; lhbcd = 4'd1;
        ampm = 1'b1;
        repeat (60) step();

        // Dash code and zero hour-tens, AM.
        rmbcd = 4'hC; lhbcd = 4'd0; ampm = 1'b0;
        repeat (50) step();

        // Randomized digits, ampm and clear pulses.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(5))
                    0: rsbcd = 4'($urandom_range(15));
                    1: lsbcd = 4'($urandom_range(15));
                    2: rmbcd = 4'($urandom_range(15));
                    3: lmbcd = 4'($urandom_range(15));
                    4: rhbcd = 4'($urandom_range(15));
                    default: lhbcd = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
                endcase
            end
            if ($urandom_range(29) == 0) ampm = ~ampm;
            clear1 = ($urandom_range(49) != 0);
            clear4 = ($urandom_range(299) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
